// File: rtl/rfphoenix_issue_pkg.sv
// Shared types for the rfPhoenix issue stage: decode bus layout, FSM states,
// stall reason codes and a register one-hot helper.
// Optional feature macro used by this slice: RFPHOENIX_SB_BYPASS_EN
package rfphoenix_issue_pkg;

    localparam int NUM_REGS = 64;

    typedef logic [5:0] reg_idx_t;

    // Decoded instruction fields handed from the decoder to the issue stage.
    // A T bit of 1 selects the vector register file, 0 the scalar file.
    typedef struct packed {
        logic [5:0]  Ra;
        logic        Ta;
        logic [5:0]  Rb;
        logic        Tb;
        logic [5:0]  Rc;
        logic        Tc;
        logic [5:0]  Rt;
        logic        Tt;
        logic        rfwr;
        logic        vrfwr;
        logic        multicycle;
        logic        load;
        logic        store;
        logic        br;
        logic        cjb;
        logic [15:0] imm;
        logic [1:0]  memsz;
    } sDecodeBus;

    // Issue pipeline register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } issue_state_e;

    // Why the held instruction is not issuing this cycle.
    typedef enum logic [1:0] {
        STALL_NONE    = 2'd0,
        STALL_HAZARD  = 2'd1,
        STALL_MCLIMIT = 2'd2,
        STALL_BUSY    = 2'd3
    } stall_e;

    // One-hot mask for a register index.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t r);
        logic [NUM_REGS-1:0] m;
        m = '0;
        m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rfphoenix_issue_scoreboard.sv
// Register scoreboard for the rfPhoenix issue stage: scalar and vector busy
// vectors plus the count of outstanding multicycle ops.
// With RFPHOENIX_SB_BYPASS_EN defined, a retire in the current cycle hides the
// retiring register from the hazard check so the dependent op can issue at once.
module rfphoenix_issue_scoreboard
    import rfphoenix_issue_pkg::*;
#(
    parameter int MC_MAX = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  reg_idx_t   ra,
    input  logic       ta,
    input  reg_idx_t   rb,
    input  logic       tb,
    input  reg_idx_t   rc,
    input  logic       tc,
    input  reg_idx_t   rt,
    input  logic       tt,
    input  logic       wr_chk,
    input  logic       set_v,
    input  reg_idx_t   set_rt,
    input  logic       set_tt,
    input  logic       clr_v,
    input  reg_idx_t   clr_rt,
    input  logic       clr_tt,
    input  logic       mc_inc,
    input  logic       mc_dec,
    output logic       hazard,
    output logic       mc_full
);

    localparam logic [2:0] MC_LIMIT = 3'(MC_MAX);

    logic [NUM_REGS-1:0] s_busy;
    logic [NUM_REGS-1:0] v_busy;
    logic [NUM_REGS-1:0] s_set;
    logic [NUM_REGS-1:0] v_set;
    logic [NUM_REGS-1:0] s_clr;
    logic [NUM_REGS-1:0] v_clr;
    logic [NUM_REGS-1:0] s_view;
    logic [NUM_REGS-1:0] v_view;
    logic [2:0]          mc_cnt;

    // Decode the set (issuing writer) and clear (retire) requests into per-file masks.
    always_comb begin
        s_set = '0;
        v_set = '0;
        s_clr = '0;
        v_clr = '0;
        if (set_v) begin
            if (set_tt) v_set = reg_onehot(set_rt);
            else        s_set = reg_onehot(set_rt);
        end
        if (clr_v) begin
            if (clr_tt) v_clr = reg_onehot(clr_rt);
            else        s_clr = reg_onehot(clr_rt);
        end
    end

    // Hazard lookup for the held instruction; scalar r0 is hard-wired not busy.
    always_comb begin
        s_view = s_busy;
        v_view = v_busy;
`ifdef RFPHOENIX_SB_BYPASS_EN
        s_view = s_busy & ~s_clr;
        v_view = v_busy & ~v_clr;
`endif
        s_view[0] = 1'b0;
        hazard = (ta ? v_view[ra] : s_view[ra])
               | (tb ? v_view[rb] : s_view[rb])
               | (tc ? v_view[rc] : s_view[rc])
               | (wr_chk & (tt ? v_view[rt] : s_view[rt]));
        mc_full = (mc_cnt == MC_LIMIT);
    end

    // Busy bits: retire clears, issue sets, set wins a same-bit collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_busy <= '0;
            v_busy <= '0;
        end else begin
            s_busy <= ((s_busy & ~s_clr) | s_set) & ~reg_onehot(6'd0);
            v_busy <= (v_busy & ~v_clr) | v_set;
        end
    end

    // Outstanding multicycle count; simultaneous inc/dec cancel, never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            mc_cnt <= 3'd0;
        end else begin
            case ({mc_inc, mc_dec})
                2'b10:   if (mc_cnt != 3'd7) mc_cnt <= mc_cnt + 3'd1;
                2'b01:   if (mc_cnt != 3'd0) mc_cnt <= mc_cnt - 3'd1;
                default: mc_cnt <= mc_cnt;
            endcase
        end
    end

endmodule

// File: rtl/rfphoenix_issue.sv
// rfPhoenix issue stage: a one-entry pipeline register between decode and
// execute that holds an instruction until its operands are free, the
// multicycle limit allows it, and execute accepts it.
// Optional feature macro: RFPHOENIX_SB_BYPASS_EN (same-cycle retire bypass
// into the hazard check, implemented in the scoreboard).
module rfphoenix_issue
    import rfphoenix_issue_pkg::*;
#(
    parameter int MC_MAX = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       dec_v_i,
    output logic       dec_rdy_o,
    input  sDecodeBus  deco_i,
    output logic       iss_v_o,
    input  logic       iss_rdy_i,
    output sDecodeBus  deco_o,
    input  logic       wb_v_i,
    input  logic [5:0] wb_Rt_i,
    input  logic       wb_Tt_i,
    input  logic       wb_mc_i,
    input  logic       flush_i,
    output logic [1:0] stall_o
);

    issue_state_e state;
    logic         full;
    logic         hazard;
    logic         mc_full;
    logic         mclimit;
    logic         fire;
    logic         accept;
    logic         writes;
    stall_e       stall_reason;

    // Issue handshake: valid, fire, ready and accept all derive from the held op.
    always_comb begin
        full      = (state == ST_FULL);
        writes    = deco_o.rfwr | deco_o.vrfwr;
        mclimit   = full & deco_o.multicycle & mc_full;
        iss_v_o   = full & ~hazard & ~mclimit & ~flush_i;
        fire      = iss_v_o & iss_rdy_i;
        dec_rdy_o = ~full | fire;
        accept    = dec_v_i & dec_rdy_o & ~flush_i;
    end

    // Stall reason for the held op, highest-priority cause first.
    always_comb begin
        stall_reason = STALL_NONE;
        if (full) begin
            if (hazard)          stall_reason = STALL_HAZARD;
            else if (mclimit)    stall_reason = STALL_MCLIMIT;
            else if (!iss_rdy_i) stall_reason = STALL_BUSY;
        end
        stall_o = stall_reason;
    end

    // Occupancy FSM and pipeline register; flush drops the held op and any accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= ST_EMPTY;
            deco_o <= '0;
        end else if (flush_i) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state  <= ST_FULL;
                        deco_o <= deco_i;
                    end
                end
                ST_FULL: begin
                    if (accept) begin
                        deco_o <= deco_i;
                    end else if (fire) begin
                        state <= ST_EMPTY;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    rfphoenix_issue_scoreboard #(
        .MC_MAX (MC_MAX)
    ) u_scoreboard (
        .clk     (clk_i),
        .rst     (rst_i),
        .ra      (deco_o.Ra),
        .ta      (deco_o.Ta),
        .rb      (deco_o.Rb),
        .tb      (deco_o.Tb),
        .rc      (deco_o.Rc),
        .tc      (deco_o.Tc),
        .rt      (deco_o.Rt),
        .tt      (deco_o.Tt),
        .wr_chk  (writes),
        .set_v   (fire & writes),
        .set_rt  (deco_o.Rt),
        .set_tt  (deco_o.Tt),
        .clr_v   (wb_v_i),
        .clr_rt  (wb_Rt_i),
        .clr_tt  (wb_Tt_i),
        .mc_inc  (fire & deco_o.multicycle),
        .mc_dec  (wb_v_i & wb_mc_i),
        .hazard  (hazard),
        .mc_full (mc_full)
    );

endmodule

// File: tb/tb_rfphoenix_issue.sv
// Testbench for rfphoenix_issue: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the issue rules.
// Honours RFPHOENIX_SB_BYPASS_EN the same way the design does.
module tb_rfphoenix_issue;
    import rfphoenix_issue_pkg::*;

    localparam int MC_MAX = 2;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       dec_v_i = 1'b0;
    logic       dec_rdy_o;
    sDecodeBus  deco_i = '0;
    logic       iss_v_o;
    logic       iss_rdy_i = 1'b0;
    sDecodeBus  deco_o;
    logic       wb_v_i = 1'b0;
    logic [5:0] wb_Rt_i = '0;
    logic       wb_Tt_i = 1'b0;
    logic       wb_mc_i = 1'b0;
    logic       flush_i = 1'b0;
    logic [1:0] stall_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: which registers have a write in flight, how many
    // multicycle ops are outstanding, and what instruction (if any) is held.
    logic [63:0] mSbusy;
    logic [63:0] mVbusy;
    int          mMc;
    bit          mFull;
    sDecodeBus   mHeld;

    logic       lastIss;
    logic       lastRdy;
    logic [1:0] lastStall;
    sDecodeBus  lastDeco;

    always #5 clk = ~clk;

    rfphoenix_issue #(.MC_MAX(MC_MAX)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .dec_v_i   (dec_v_i),
        .dec_rdy_o (dec_rdy_o),
        .deco_i    (deco_i),
        .iss_v_o   (iss_v_o),
        .iss_rdy_i (iss_rdy_i),
        .deco_o    (deco_o),
        .wb_v_i    (wb_v_i),
        .wb_Rt_i   (wb_Rt_i),
        .wb_Tt_i   (wb_Tt_i),
        .wb_mc_i   (wb_mc_i),
        .flush_i   (flush_i),
        .stall_o   (stall_o)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic sDecodeBus mkOp(input logic [5:0] ra, input logic ta, input logic [5:0] rb, input logic tb,
                                       input logic [5:0] rc, input logic tc, input logic [5:0] rt, input logic tt,
                                       input logic rfwr, input logic vrfwr, input logic mc);
        sDecodeBus d;
        d = '0;
        d.Ra = ra; d.Ta = ta; d.Rb = rb; d.Tb = tb; d.Rc = rc; d.Tc = tc;
        d.Rt = rt; d.Tt = tt; d.rfwr = rfwr; d.vrfwr = vrfwr;
        d.multicycle = mc; d.load = mc;
        d.imm = 16'($urandom_range(0, 65535));
        d.memsz = 2'($urandom_range(0, 3));
        return d;
    endfunction

    function automatic bit isBusy(input logic [63:0] s, input logic [63:0] v, input logic [5:0] r, input logic t);
        if (t) return v[r];
        return (r != 6'd0) && s[r];
    endfunction

    task automatic modelReset();
        mSbusy = '0;
        mVbusy = '0;
        mMc    = 0;
        mFull  = 0;
        mHeld  = '0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_i = 1'b1; dec_v_i = 1'b0; wb_v_i = 1'b0; flush_i = 1'b0; iss_rdy_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        modelReset();
    endtask

    // One clock of stimulus: drive inputs, compare against the model, advance the model.
    task automatic applyStimulus(input logic dv, input sDecodeBus d, input logic irdy,
                                 input logic wbv, input logic [5:0] wbrt, input logic wbtt,
                                 input logic wbmc, input logic fl);
        logic [63:0] sv;
        logic [63:0] vv;
        bit haz, mcl, expIss, expFire, expRdy, acc;
        logic [1:0] expStall;
        @(negedge clk);
        dec_v_i = dv; deco_i = d; iss_rdy_i = irdy;
        wb_v_i = wbv; wb_Rt_i = wbrt; wb_Tt_i = wbtt; wb_mc_i = wbmc; flush_i = fl;
        #1;
        sv = mSbusy;
        vv = mVbusy;
`ifdef RFPHOENIX_SB_BYPASS_EN
        if (wbv) begin
            if (wbtt) vv[wbrt] = 1'b0;
            else      sv[wbrt] = 1'b0;
        end
`endif
        haz = mFull && (isBusy(sv, vv, mHeld.Ra, mHeld.Ta) || isBusy(sv, vv, mHeld.Rb, mHeld.Tb) ||
                        isBusy(sv, vv, mHeld.Rc, mHeld.Tc) ||
                        ((mHeld.rfwr || mHeld.vrfwr) && isBusy(sv, vv, mHeld.Rt, mHeld.Tt)));
        mcl = mFull && mHeld.multicycle && (mMc == MC_MAX);
        expIss  = mFull && !haz && !mcl && !fl;
        expFire = expIss && irdy;
        expRdy  = !mFull || expFire;
        if (!mFull)     expStall = 2'd0;
        else if (haz)   expStall = 2'd1;
        else if (mcl)   expStall = 2'd2;
        else if (!irdy) expStall = 2'd3;
        else            expStall = 2'd0;

        checkOutput("iss_v", 64'(iss_v_o), 64'(expIss));
        checkOutput("dec_rdy", 64'(dec_rdy_o), 64'(expRdy));
        checkOutput("stall", 64'(stall_o), 64'(expStall));
        if (mFull) checkOutput("deco_o", 64'(deco_o), 64'(mHeld));
        lastIss = iss_v_o; lastRdy = dec_rdy_o; lastStall = stall_o; lastDeco = deco_o;

        acc = dv && expRdy && !fl;
        if (wbv) begin
            if (wbtt) mVbusy[wbrt] = 1'b0;
            else      mSbusy[wbrt] = 1'b0;
        end
        if (expFire && (mHeld.rfwr || mHeld.vrfwr)) begin
            if (mHeld.Tt)                mVbusy[mHeld.Rt] = 1'b1;
            else if (mHeld.Rt != 6'd0)   mSbusy[mHeld.Rt] = 1'b1;
        end
        if (expFire && mHeld.multicycle && !(wbv && wbmc)) mMc = (mMc < 7) ? mMc + 1 : 7;
        if (wbv && wbmc && !(expFire && mHeld.multicycle)) mMc = (mMc > 0) ? mMc - 1 : 0;
        if (fl)            mFull = 0;
        else if (acc)      begin mFull = 1; mHeld = d; end
        else if (expFire)  mFull = 0;
    endtask

    task automatic idle(input logic irdy);
        applyStimulus(1'b0, '0, irdy, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        sDecodeBus a, b, op;
        modelReset();

        // Reset state
        applyReset();
        idle(1'b1);
        checkOutput("rst_iss_v", 64'(lastIss), 64'd0);
        checkOutput("rst_dec_rdy", 64'(lastRdy), 64'd1);
        checkOutput("rst_stall", 64'(lastStall), 64'd0);
        checkOutput("rst_deco", 64'(lastDeco), 64'd0);

        // RAW on scalar r5
        applyReset();
        a = mkOp(6'd1, 0, 6'd1, 0, 6'd1, 0, 6'd5, 0, 1, 0, 0);
        b = mkOp(6'd5, 0, 6'd1, 0, 6'd1, 0, 6'd2, 0, 0, 0, 0);
        applyStimulus(1, a, 1, 0, 6'd0, 0, 0, 0);
        applyStimulus(1, b, 1, 0, 6'd0, 0, 0, 0);
        idle(1'b1);
        checkOutput("raw_stall", 64'(lastStall), 64'd1);
        applyStimulus(0, '0, 1, 1, 6'd5, 0, 0, 0);
`ifdef RFPHOENIX_SB_BYPASS_EN
        checkOutput("raw_bypass_iss", 64'(lastIss), 64'd1);
`else
        checkOutput("raw_retire_stall", 64'(lastStall), 64'd1);
        idle(1'b1);
        checkOutput("raw_after_iss", 64'(lastIss), 64'd1);
`endif

        // Scalar r0 never busy
        applyReset();
        a = mkOp(6'd1, 0, 6'd1, 0, 6'd1, 0, 6'd0, 0, 1, 0, 0);
        b = mkOp(6'd0, 0, 6'd0, 0, 6'd0, 0, 6'd3, 0, 0, 0, 0);
        applyStimulus(1, a, 1, 0, 6'd0, 0, 0, 0);
        applyStimulus(1, b, 1, 0, 6'd0, 0, 0, 0);
        idle(1'b1);
        checkOutput("r0_stall", 64'(lastStall), 64'd0);
        checkOutput("r0_iss", 64'(lastIss), 64'd1);

        // Multicycle limit with three back-to-back loads
        applyReset();
        op = mkOp(6'd1, 0, 6'd1, 0, 6'd1, 0, 6'd0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, op, 1, 0, 6'd0, 0, 0, 0);
        idle(1'b1);
        checkOutput("mc_stall", 64'(lastStall), 64'd2);
        applyStimulus(0, '0, 1, 1, 6'd63, 0, 1, 0);
        checkOutput("mc_retire_stall", 64'(lastStall), 64'd2);
        idle(1'b1);
        checkOutput("mc_release_iss", 64'(lastIss), 64'd1);

        // Set/clear collision on vector r7
        applyReset();
        a = mkOp(6'd1, 0, 6'd1, 0, 6'd1, 0, 6'd7, 1, 0, 1, 0);
        b = mkOp(6'd7, 1, 6'd1, 0, 6'd1, 0, 6'd0, 0, 0, 0, 0);
        applyStimulus(1, a, 1, 0, 6'd0, 0, 0, 0);
        applyStimulus(1, b, 1, 1, 6'd7, 1, 0, 0);
        idle(1'b1);
        checkOutput("collide_stall", 64'(lastStall), 64'd1);
        idle(1'b1);
        checkOutput("collide_hold", 64'(lastStall), 64'd1);

        // Flush with a held op and a simultaneous accept
        applyReset();
        a = mkOp(6'd1, 0, 6'd1, 0, 6'd1, 0, 6'd3, 0, 1, 0, 0);
        b = mkOp(6'd3, 0, 6'd1, 0, 6'd1, 0, 6'd0, 0, 0, 0, 0);
        applyStimulus(1, a, 1, 0, 6'd0, 0, 0, 0);
        applyStimulus(1, b, 1, 0, 6'd0, 0, 0, 0);
        idle(1'b1);
        applyStimulus(1, a, 1, 0, 6'd0, 0, 0, 1);
        checkOutput("flush_iss", 64'(lastIss), 64'd0);
        idle(1'b1);
        checkOutput("flush_empty_rdy", 64'(lastRdy), 64'd1);
        checkOutput("flush_empty_stall", 64'(lastStall), 64'd0);
        applyStimulus(1, b, 1, 0, 6'd0, 0, 0, 0);
        idle(1'b1);
        checkOutput("flush_busy_kept", 64'(lastStall), 64'd1);

        // Back-to-back independent ops
        applyReset();
        for (int i = 0; i < 8; i++) begin
            op = mkOp(6'd1, 0, 6'd2, 0, 6'd3, 1, 6'(10 + i), 0, 1, 0, 0);
            applyStimulus(1, op, 1, 0, 6'd0, 0, 0, 0);
            checkOutput("b2b_rdy", 64'(lastRdy), 64'd1);
            if (i > 0) checkOutput("b2b_iss", 64'(lastIss), 64'd1);
        end

        // Random traffic over a small register window so hazards are frequent
        applyReset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                applyReset();
            end else begin
                op = mkOp(6'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
                          6'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
                          6'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
                          6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 3) == 0));
                applyStimulus(1'($urandom_range(0, 3) != 0), op,
                              1'($urandom_range(0, 3) != 0),
                              1'($urandom_range(0, 2) == 0), 6'($urandom_range(0, 7)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 29) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
